mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds to the core's data-memory store/load bus (addr_in, data_in, wr_en, fn3, data_out). The core is the initiator; this block is the responder. Stores enqueue bytes into a TX FIFO, and an FSM serialises them as 8N1 frames on the board's tx pin. Loads return status and baud-divider registers. The top-level read mux selects data_out when hit=1.

Parameters:
BASE_ADDR, 32'h10000000, base of the 16-byte register window. Bits [3:0] are ignored for decode.
FIFO_DEPTH, 8, TX FIFO entries. Must be a power of 2 and at most 128.
DEFAULT_DIV, 16'd234, reset value of BAUDDIV. This gives 115200 baud at 27 MHz.

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
addr_in  input  32  byte address from the core's data bus
data_in  input  32  store data (rs2 value)
wr_en  input  1  store strobe, sampled at posedge clk
fn3  input  3  load/store width code (instruction[14:12])
data_out  output  32  combinational load data; 0 when hit=0
hit  output  1  combinational; 1 when addr_in[31:4]==BASE_ADDR[31:4]
tx  output  1  registered serial output; idles high

Behaviour:
- Register map (addr_in[3:2]; addr_in[1:0] ignored):
  - 0x0 TXDATA: write-only. Reads return 0.
  - 0x4 STATUS: read-only fields; a write has the side effect of clearing overflow.
  - 0x8 BAUDDIV: R/W, 16 bits, upper bits read as 0.
  - 0xC: reserved. Reads 0, writes ignored.
- STATUS fields:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM != IDLE)
  - bit3 overflow (sticky)
  - [15:8] fifo count
  - all other bits 0
- Store handling, when hit && wr_en at posedge:
  - TXDATA: push data_in[7:0] for any store width.
  - BAUDDIV with fn3[1:0]==00 (SB): write [7:0] only. Any other width writes [15:0].
- Load extension, applied to the selected 32-bit register value:
  - 000 (LB): sign-extend [7:0]
  - 001 (LH): sign-extend [15:0]
  - 100 (LBU): zero-extend [7:0]
  - 101 (LHU): zero-extend [15:0]
  - all others: full word
- Push when full: dropped; overflow sets to 1 at that edge. Fullness uses the count before the edge, so the push is dropped even if a pop happens the same cycle.
- Push and pop in the same cycle when not full: both happen; count is unchanged.
- FSM states IDLE, START, DATA, STOP, with a bit-timer and a 3-bit bit index.
  - IDLE: if FIFO non-empty at posedge, pop into the shift register, latch div = max(BAUDDIV, 1), and go to START. An empty FIFO with a simultaneous push does not pop; the pop happens at the next edge.
  - START: tx=0 for div cycles, then DATA.
  - DATA: 8 bits, LSB first, each held div cycles, then STOP.
  - STOP: tx=1 for div cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- BAUDDIV writes mid-frame affect only the next frame.
- Latency: a store at edge N gives a pop at edge N+1. tx falls after edge N+1 and remains low for div cycles. Frame length is exactly 10*div cycles.
- tx is driven from a flop: low in START, data bit in DATA, high in IDLE/STOP.
- Reset (asynchronous, including mid-frame) forces immediately:
  - tx=1, FSM=IDLE, FIFO empty (count 0), overflow=0, BAUDDIV=DEFAULT_DIV
  - data_out/hit remain combinational on addr.

Test Plan:
- Reset: assert rst, release. Expect tx=1, LW STATUS=0x00000002, LW BAUDDIV=0x000000EA, LW 0x1000000C=0, LW 0x20000000 gives data_out=0 and hit=0.
- Single frame: SW BAUDDIV=4, then SB 0x55 to TXDATA at edge N. Expect tx low for cycles N+1..N+4, then 1,0,1,0,1,0,1,0 four cycles each, stop high for 4. busy=1 for 40 cycles, then STATUS=0x2.
- Overflow: BAUDDIV=1000, ten SB stores on consecutive cycles. The first byte is popped, so STATUS=0x0000080D (count 8, overflow, busy, full). SW 0 to STATUS then reads 0x00000805.
- Back-to-back: BAUDDIV=2, SB 0x00 then SB 0xFF on consecutive cycles. Expect 40 cycles of contiguous frames with the second start bit immediately after the first stop bit. tx ends high and busy=0.
- Width handling: SH 0x8001 to BAUDDIV. LH returns 0xFFFF8001, LHU returns 0x00008001. Then SB 0xAB gives LW=0x000080AB.
- Reset mid-frame: assert rst during DATA with 3 bytes queued. Expect tx=1 in the same cycle (async), and after release STATUS=0x2 and BAUDDIV=0xEA.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue bytes in a small
// FIFO; a four-state FSM shifts them out LSB first on tx. Loads return the
// STATUS and BAUDDIV registers with RISC-V style width/sign extension.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        wr_en,
  input  logic [2:0]  fn3,
  output logic [31:0] data_out,
  output logic        hit,
  output logic        tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Register-window decode
  logic [1:0] sel;
  logic       bus_wr;
  assign hit    = (addr_in[31:4] == BASE_ADDR[31:4]);
  assign sel    = addr_in[3:2];
  assign bus_wr = hit && wr_en;

  // Byte-lane address bits and upper store data have no meaning in this block.
  logic unused_bits;
  assign unused_bits = ^{addr_in[1:0], data_in[31:16]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push_req, push, pop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus_wr && (sel == REG_TXDATA);
  assign push     = push_req && !full;

  // FIFO storage write port
  // NOTE: storage arrays carry no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [15:0] baud_div;
  logic        overflow;

  // BAUDDIV writes and sticky overflow flag (cleared by any STATUS write)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (bus_wr && sel == REG_BAUDDIV) begin
        if (fn3[1:0] == 2'b00) baud_div[7:0] <= data_in[7:0];
        else                   baud_div      <= data_in[15:0];
      end
      if (push_req && full)                     overflow <= 1'b1;
      else if (bus_wr && sel == REG_STATUS)     overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_d;
  logic [15:0] timer, timer_d, div_q, div_d, load_div;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        tx_d, busy;

  assign load_div = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign busy     = (state != S_IDLE);

  // State and datapath registers; tx comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      div_q   <= 16'd1;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      div_q   <= div_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
    end
  end

  // Next-state logic: each bit period counts timer down from div-1 to 0
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    div_d     = div_q;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    tx_d      = tx;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = fifo_mem[rd_ptr];
          div_d   = load_div;
          timer_d = load_div - 16'd1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer == 16'd0) begin
          tx_d      = shreg[0];
          shreg_d   = shreg >> 1;
          bit_idx_d = 3'd0;
          timer_d   = div_q - 16'd1;
          state_d   = S_DATA;
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      S_DATA: begin
        if (timer == 16'd0) begin
          timer_d = div_q - 16'd1;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d      = shreg[0];
            shreg_d   = shreg >> 1;
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      S_STOP: begin
        if (timer == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = fifo_mem[rd_ptr];
            div_d   = load_div;
            timer_d = load_div - 16'd1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  logic [31:0] reg_val, ext_val;

  // Register select followed by load-width extension
  always_comb begin
    reg_val = 32'd0;
    case (sel)
      REG_STATUS:  reg_val = {16'd0, 8'(count), 4'd0, overflow, busy, empty, full};
      REG_BAUDDIV: reg_val = {16'd0, baud_div};
      default:     reg_val = 32'd0;
    endcase
    case (fn3)
      3'b000:  ext_val = {{24{reg_val[7]}}, reg_val[7:0]};
      3'b001:  ext_val = {{16{reg_val[15]}}, reg_val[15:0]};
      3'b100:  ext_val = {24'd0, reg_val[7:0]};
      3'b101:  ext_val = {16'd0, reg_val[15:0]};
      default: ext_val = reg_val;
    endcase
    data_out = hit ? ext_val : 32'd0;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx: register map, frame timing,
// overflow, back-to-back frames, load widths and asynchronous reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_BD  = 32'h1000_0008;
  localparam logic [31:0] A_RS  = 32'h1000_000C;
  localparam logic [31:0] A_OFF = 32'h2000_0000;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk, rst, wr_en, hit, tx;
  logic [31:0] addr_in, data_in, data_out;
  logic [2:0]  fn3;

  int n_checks = 0;
  int n_errors = 0;

  mmio_uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .fn3      (fn3),
    .data_out (data_out),
    .hit      (hit),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Store issued on the next rising edge; returns 1 time unit after that edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    addr_in = a;
    data_in = d;
    fn3     = f;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d);
    @(negedge clk);
    addr_in = a;
    fn3     = f;
    wr_en   = 1'b0;
    #1;
    d = data_out;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] rd;
  logic [7:0]  fb;
  logic        exp_tx;

  initial begin
    rst = 1'b1; wr_en = 1'b0; addr_in = '0; data_in = '0; fn3 = '0;
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ---- reset state ----
    bus_read(A_ST, F_W, rd);  check("rst_status", rd, 32'h0000_0002);
    check("rst_hit", {31'd0, hit}, 32'd1);
    bus_read(A_BD, F_W, rd);  check("rst_baud", rd, 32'h0000_00EA);
    bus_read(A_RS, F_W, rd);  check("rst_reserved", rd, 32'd0);
    bus_read(A_TX, F_W, rd);  check("txdata_read", rd, 32'd0);
    bus_read(A_OFF, F_W, rd); check("miss_data", rd, 32'd0);
    check("miss_hit", {31'd0, hit}, 32'd0);

    // ---- single frame 0x55 at div 4 ----
    bus_write(A_BD, 32'd4, F_W);
    bus_write(A_TX, 32'h55, F_B);   // edge N
    addr_in = A_ST; fn3 = F_W;
    fb = 8'h55;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i < 4)       exp_tx = 1'b0;
      else if (i < 36) exp_tx = fb[(i - 4) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("frame55_tx[%0d]", i), {31'd0, tx}, {31'd0, exp_tx});
      check($sformatf("frame55_busy[%0d]", i), {31'd0, data_out[2]}, 32'd1);
    end
    @(posedge clk); #1;
    check("frame55_idle_status", data_out, 32'h0000_0002);
    check("frame55_idle_tx", {31'd0, tx}, 32'd1);

    // ---- overflow ----
    bus_write(A_BD, 32'd1000, F_W);
    for (int i = 0; i < 10; i++) bus_write(A_TX, 32'(i), F_B);
    bus_read(A_ST, F_W, rd);  check("ovf_status", rd, 32'h0000_080D);
    bus_write(A_ST, 32'd0, F_W);
    bus_read(A_ST, F_W, rd);  check("ovf_cleared", rd, 32'h0000_0805);
    do_reset();
    bus_read(A_ST, F_W, rd);  check("ovf_after_rst", rd, 32'h0000_0002);

    // ---- back-to-back frames 0x00, 0xFF at div 2 ----
    bus_write(A_BD, 32'd2, F_W);
    bus_write(A_TX, 32'h00, F_B);   // edge N
    bus_write(A_TX, 32'hFF, F_B);   // edge N+1, first pop happens here
    addr_in = A_ST; fn3 = F_W;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i < 2)       exp_tx = 1'b0;   // start 1
      else if (i < 18) exp_tx = 1'b0;   // data 0x00
      else if (i < 20) exp_tx = 1'b1;   // stop 1
      else if (i < 22) exp_tx = 1'b0;   // start 2
      else             exp_tx = 1'b1;   // data 0xFF + stop 2
      check($sformatf("b2b_tx[%0d]", i), {31'd0, tx}, {31'd0, exp_tx});
    end
    @(posedge clk); #1;
    check("b2b_end_tx", {31'd0, tx}, 32'd1);
    check("b2b_end_status", data_out, 32'h0000_0002);

    // ---- load/store widths ----
    bus_write(A_BD, 32'h0000_8001, F_H);
    bus_read(A_BD, F_H, rd);  check("lh_baud", rd, 32'hFFFF_8001);
    bus_read(A_BD, F_HU, rd); check("lhu_baud", rd, 32'h0000_8001);
    bus_write(A_BD, 32'h1234_56AB, F_B);
    bus_read(A_BD, F_W, rd);  check("sb_baud_lw", rd, 32'h0000_80AB);
    bus_read(A_BD, F_B, rd);  check("lb_baud", rd, 32'hFFFF_FFAB);
    bus_read(A_BD, F_BU, rd); check("lbu_baud", rd, 32'h0000_00AB);
    bus_write(A_RS, 32'hFFFF_FFFF, F_W);
    bus_read(A_RS, F_W, rd);  check("reserved_wr", rd, 32'd0);
    bus_read(A_BD, F_W, rd);  check("reserved_no_alias", rd, 32'h0000_80AB);

    // ---- asynchronous reset during DATA ----
    bus_write(A_BD, 32'd4, F_W);
    for (int i = 0; i < 4; i++) bus_write(A_TX, 32'h00, F_B);  // edges N..N+3
    repeat (4) @(posedge clk);                                  // edge N+7: in DATA
    #1;
    addr_in = A_ST; fn3 = F_W;
    #1;
    check("mid_status", data_out, 32'h0000_0304);
    check("mid_tx_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(A_ST, F_W, rd);  check("mid_rst_status", rd, 32'h0000_0002);
    bus_read(A_BD, F_W, rd);  check("mid_rst_baud", rd, 32'h0000_00EA);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_tx_idle", {31'd0, tx}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
